// File: rtl/pixel_pkg.sv
// Shared types for the pixel reorder queue.
//
// Holds the default coordinate and colour widths, the matching scalar types,
// and the entry record moved between the engines and the combinator.
// Modules take their parameter defaults from here, so the typed view and the
// default-parameter RTL always agree.
package pixel_pkg;

   localparam int PIX_DATA_WIDTH = 10;
   localparam int PIX_RBG_SIZE   = 24;

   typedef logic [PIX_DATA_WIDTH-1:0] coord_t;
   typedef logic [PIX_RBG_SIZE-1:0]   colour_t;

   typedef struct packed {
      colour_t colour;
      coord_t  x;
      coord_t  y;
   } pixel_entry_t;

endpackage

// File: rtl/pixel_fifo.sv
// One channel of the pixel reorder queue.
//
// This is a circular FIFO holding (colour, x, y) entries. When DEDUP is set, a
// push whose x equals the last accepted x is consumed but not stored.
//
// Ports:
//   clk, reset                    clock, synchronous active-low reset
//   push_valid / push_ready       push handshake; push_ready = not full
//   push_colour, push_x, push_y   entry offered by the engine
//   pop                           remove the head (ignored when empty)
//   head_colour, head_x, head_y   current head entry (valid when !empty)
//   empty, full                   occupancy flags
module pixel_fifo
   import pixel_pkg::*;
#(
   parameter int DATA_WIDTH = PIX_DATA_WIDTH,
   parameter int RBG_SIZE   = PIX_RBG_SIZE,
   parameter int QUEUE_SIZE = 8,
   parameter int DEDUP      = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  push_valid,
   output logic                  push_ready,
   input  logic [RBG_SIZE-1:0]   push_colour,
   input  logic [DATA_WIDTH-1:0] push_x,
   input  logic [DATA_WIDTH-1:0] push_y,
   input  logic                  pop,
   output logic [RBG_SIZE-1:0]   head_colour,
   output logic [DATA_WIDTH-1:0] head_x,
   output logic [DATA_WIDTH-1:0] head_y,
   output logic                  empty,
   output logic                  full
);

   localparam int PW = $clog2(QUEUE_SIZE);
   localparam int CW = $clog2(QUEUE_SIZE + 1);

   logic [RBG_SIZE-1:0]   colour_mem [QUEUE_SIZE];
   logic [DATA_WIDTH-1:0] x_mem      [QUEUE_SIZE];
   logic [DATA_WIDTH-1:0] y_mem      [QUEUE_SIZE];

   logic [PW-1:0]         rd_ptr;
   logic [PW-1:0]         wr_ptr;
   logic [CW-1:0]         count;
   logic [DATA_WIDTH-1:0] last_x;
   logic                  last_valid;

   logic do_push;
   logic do_store;
   logic do_pop;
   logic is_dup;

   assign empty      = (count == '0);
   assign full       = (count == CW'(QUEUE_SIZE));
   // Readiness depends only on occupancy, never on a same-cycle pop.
   assign push_ready = !full;

   assign is_dup   = (DEDUP != 0) && last_valid && (push_x == last_x);
   assign do_push  = push_valid && push_ready;
   assign do_store = do_push && !is_dup;
   assign do_pop   = pop && !empty;

   assign head_colour = colour_mem[rd_ptr];
   assign head_x      = x_mem[rd_ptr];
   assign head_y      = y_mem[rd_ptr];

   // Storage needs no reset; only slots behind the pointers are ever read.
   always_ff @(posedge clk) begin
      if (reset && do_store) begin
         colour_mem[wr_ptr] <= push_colour;
         x_mem[wr_ptr]      <= push_x;
         y_mem[wr_ptr]      <= push_y;
      end
   end

   // QUEUE_SIZE is a power of two, so the pointers wrap naturally.
   always_ff @(posedge clk) begin
      if (!reset) begin
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         count      <= '0;
         last_x     <= '0;
         last_valid <= 1'b0;
      end else begin
         if (do_store) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)   rd_ptr <= rd_ptr + 1'b1;
         case ({do_store, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         // A dropped duplicate still counts as accepted; its x equals last_x anyway.
         if (do_push) begin
            last_x     <= push_x;
            last_valid <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/pixel_reorder_queue.sv
// Pixel reorder queue: engine channels feed independent FIFOs. The combinator
// asks for the next coordinate (xpixel_check, ypixel_check). The lowest-index
// non-empty channel whose head matches that coordinate is popped into a
// registered output stage.
//
// Handshake: a push on channel c happens when in_valid[c] && in_ready[c]. The
// output transfers when out_valid && out_ready. While out_valid is high and
// out_ready is low, the outputs are held stable.
//
// Ports:
//   clk, reset                        clock, synchronous active-low reset
//   in_valid, in_ready                per-channel push handshake
//   colour_i, xpixel_i, ypixel_i      packed per-channel push data
//   xpixel_check, ypixel_check        coordinate the combinator wants next
//   out_ready, out_valid              output handshake
//   colour_o, xpixel_o, ypixel_o      registered output entry
//   match                             some non-empty head equals the check coordinate
//   full_queue, empty                 per-channel occupancy flags
//   stall                             all channels occupied, nothing matches, output idle
module pixel_reorder_queue
   import pixel_pkg::*;
#(
   parameter int DATA_WIDTH = PIX_DATA_WIDTH,
   parameter int RBG_SIZE   = PIX_RBG_SIZE,
   parameter int QUEUE_SIZE = 8,
   parameter int NUM_CH     = 4,
   parameter int DEDUP      = 1
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [NUM_CH-1:0]            in_valid,
   output logic [NUM_CH-1:0]            in_ready,
   input  logic [NUM_CH*RBG_SIZE-1:0]   colour_i,
   input  logic [NUM_CH*DATA_WIDTH-1:0] xpixel_i,
   input  logic [NUM_CH*DATA_WIDTH-1:0] ypixel_i,
   input  logic [DATA_WIDTH-1:0]        xpixel_check,
   input  logic [DATA_WIDTH-1:0]        ypixel_check,
   input  logic                         out_ready,
   output logic                         out_valid,
   output logic [RBG_SIZE-1:0]          colour_o,
   output logic [DATA_WIDTH-1:0]        xpixel_o,
   output logic [DATA_WIDTH-1:0]        ypixel_o,
   output logic                         match,
   output logic [NUM_CH-1:0]            full_queue,
   output logic [NUM_CH-1:0]            empty,
   output logic                         stall
);

   logic [RBG_SIZE-1:0]   head_colour [NUM_CH];
   logic [DATA_WIDTH-1:0] head_x      [NUM_CH];
   logic [DATA_WIDTH-1:0] head_y      [NUM_CH];

   logic [NUM_CH-1:0]     hit;
   logic [NUM_CH-1:0]     sel_onehot;
   logic [NUM_CH-1:0]     pop;
   logic                  fire;
   logic [RBG_SIZE-1:0]   sel_colour;
   logic [DATA_WIDTH-1:0] sel_x;
   logic [DATA_WIDTH-1:0] sel_y;

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      pixel_fifo #(
         .DATA_WIDTH (DATA_WIDTH),
         .RBG_SIZE   (RBG_SIZE),
         .QUEUE_SIZE (QUEUE_SIZE),
         .DEDUP      (DEDUP)
      ) u_fifo (
         .clk         (clk),
         .reset       (reset),
         .push_valid  (in_valid[c]),
         .push_ready  (in_ready[c]),
         .push_colour (colour_i[c*RBG_SIZE +: RBG_SIZE]),
         .push_x      (xpixel_i[c*DATA_WIDTH +: DATA_WIDTH]),
         .push_y      (ypixel_i[c*DATA_WIDTH +: DATA_WIDTH]),
         .pop         (pop[c]),
         .head_colour (head_colour[c]),
         .head_x      (head_x[c]),
         .head_y      (head_y[c]),
         .empty       (empty[c]),
         .full        (full_queue[c])
      );
   end

   // Empty channels are excluded, so stale storage can never match.
   always_comb begin
      hit = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         hit[c] = !empty[c] && (head_x[c] == xpixel_check) && (head_y[c] == ypixel_check);
      end
   end

   // Isolate the lowest set bit: the lowest matching channel wins.
   assign sel_onehot = hit & (~hit + NUM_CH'(1));
   assign match      = |hit;
   assign fire       = match && (!out_valid || out_ready);
   assign pop        = sel_onehot & {NUM_CH{fire}};
   assign stall      = (&(~empty)) && !match && !out_valid;

   // OR-mux is safe because sel_onehot has at most one bit set.
   always_comb begin
      sel_colour = '0;
      sel_x      = '0;
      sel_y      = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         if (sel_onehot[c]) begin
            sel_colour = sel_colour | head_colour[c];
            sel_x      = sel_x | head_x[c];
            sel_y      = sel_y | head_y[c];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         out_valid <= 1'b0;
         colour_o  <= '0;
         xpixel_o  <= '0;
         ypixel_o  <= '0;
      end else if (fire) begin
         out_valid <= 1'b1;
         colour_o  <= sel_colour;
         xpixel_o  <= sel_x;
         ypixel_o  <= sel_y;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_pixel_reorder_queue.sv
module tb_pixel_reorder_queue;
   import pixel_pkg::*;

   localparam int NC = 4;
   localparam int QS = 8;
   localparam int DW = PIX_DATA_WIDTH;
   localparam int CW = PIX_RBG_SIZE;

   // Clock / reset
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic reset;

   // DUT signals
   logic [NC-1:0]    in_valid;
   logic [NC-1:0]    in_ready;
   logic [NC*CW-1:0] colour_i;
   logic [NC*DW-1:0] xpixel_i;
   logic [NC*DW-1:0] ypixel_i;
   logic [DW-1:0]    xpixel_check;
   logic [DW-1:0]    ypixel_check;
   logic             out_ready;
   logic             out_valid;
   logic [CW-1:0]    colour_o;
   logic [DW-1:0]    xpixel_o;
   logic [DW-1:0]    ypixel_o;
   logic             match;
   logic [NC-1:0]    full_queue;
   logic [NC-1:0]    empty;
   logic             stall;

   // Second instance without dedup, sharing all inputs
   logic [NC-1:0]    nd_in_ready;
   logic             nd_out_valid;
   logic [CW-1:0]    nd_colour_o;
   logic [DW-1:0]    nd_xpixel_o;
   logic [DW-1:0]    nd_ypixel_o;
   logic             nd_match;
   logic [NC-1:0]    nd_full_queue;
   logic [NC-1:0]    nd_empty;
   logic             nd_stall;

   pixel_reorder_queue #(.DATA_WIDTH(DW), .RBG_SIZE(CW), .QUEUE_SIZE(QS), .NUM_CH(NC), .DEDUP(1)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .colour_i(colour_i), .xpixel_i(xpixel_i), .ypixel_i(ypixel_i),
      .xpixel_check(xpixel_check), .ypixel_check(ypixel_check),
      .out_ready(out_ready), .out_valid(out_valid), .colour_o(colour_o),
      .xpixel_o(xpixel_o), .ypixel_o(ypixel_o), .match(match),
      .full_queue(full_queue), .empty(empty), .stall(stall)
   );

   pixel_reorder_queue #(.DATA_WIDTH(DW), .RBG_SIZE(CW), .QUEUE_SIZE(QS), .NUM_CH(NC), .DEDUP(0)) dut_nd (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(nd_in_ready),
      .colour_i(colour_i), .xpixel_i(xpixel_i), .ypixel_i(ypixel_i),
      .xpixel_check(xpixel_check), .ypixel_check(ypixel_check),
      .out_ready(out_ready), .out_valid(nd_out_valid), .colour_o(nd_colour_o),
      .xpixel_o(nd_xpixel_o), .ypixel_o(nd_ypixel_o), .match(nd_match),
      .full_queue(nd_full_queue), .empty(nd_empty), .stall(nd_stall)
   );

   int vectors     = 0;
   int miscompares = 0;

   // Reference model: one queue of entries per channel plus the output stage
   pixel_entry_t mq [NC][$];
   coord_t       last_x [NC];
   bit           last_v [NC];
   bit           m_ov;
   colour_t      m_col;
   coord_t       m_x;
   coord_t       m_y;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Lowest channel whose non-empty head equals the check coordinate, or -1.
   function automatic int model_sel();
      for (int c = 0; c < NC; c++) begin
         if (mq[c].size() > 0 && mq[c][0].x == xpixel_check && mq[c][0].y == ypixel_check)
            return c;
      end
      return -1;
   endfunction

   task automatic check_outputs();
      logic [NC-1:0] e_ready, e_empty, e_full;
      bit all_busy = 1'b1;
      bit e_match;
      for (int c = 0; c < NC; c++) begin
         e_ready[c] = mq[c].size() < QS;
         e_empty[c] = mq[c].size() == 0;
         e_full[c]  = mq[c].size() == QS;
         if (mq[c].size() == 0) all_busy = 1'b0;
      end
      e_match = model_sel() >= 0;
      chk("in_ready",   in_ready,   e_ready);
      chk("empty",      empty,      e_empty);
      chk("full_queue", full_queue, e_full);
      chk("match",      match,      e_match);
      chk("stall",      stall,      all_busy && !e_match && !m_ov);
      chk("out_valid",  out_valid,  m_ov);
      chk("colour_o",   colour_o,   m_col);
      chk("xpixel_o",   xpixel_o,   m_x);
      chk("ypixel_o",   ypixel_o,   m_y);
   endtask

   // Advance the model by one clock edge using the inputs currently driven.
   task automatic model_edge();
      int sel;
      int pre [NC];
      pixel_entry_t e;
      coord_t x;
      if (!reset) begin
         for (int c = 0; c < NC; c++) begin
            mq[c].delete();
            last_v[c] = 1'b0;
         end
         m_ov = 1'b0; m_col = '0; m_x = '0; m_y = '0;
         return;
      end
      for (int c = 0; c < NC; c++) pre[c] = mq[c].size();
      sel = model_sel();
      if (sel >= 0 && (!m_ov || out_ready)) begin
         e = mq[sel].pop_front();
         m_ov = 1'b1; m_col = e.colour; m_x = e.x; m_y = e.y;
      end else if (out_ready) begin
         m_ov = 1'b0;
      end
      for (int c = 0; c < NC; c++) begin
         if (in_valid[c] && pre[c] < QS) begin
            x = xpixel_i[c*DW +: DW];
            if (!(last_v[c] && last_x[c] == x)) begin
               e.colour = colour_i[c*CW +: CW];
               e.x      = x;
               e.y      = ypixel_i[c*DW +: DW];
               mq[c].push_back(e);
            end
            last_v[c] = 1'b1;
            last_x[c] = x;
         end
      end
   endtask

   // Check the settled outputs, step the model, then advance one clock.
   task automatic cycle();
      #1;
      check_outputs();
      model_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int c, input logic [CW-1:0] col, input logic [DW-1:0] x, input logic [DW-1:0] y);
      in_valid[c]           = 1'b1;
      colour_i[c*CW +: CW]  = col;
      xpixel_i[c*DW +: DW]  = x;
      ypixel_i[c*DW +: DW]  = y;
   endtask

   task automatic idle();
      in_valid = '0;
   endtask

   task automatic set_check(input logic [DW-1:0] x, input logic [DW-1:0] y);
      xpixel_check = x;
      ypixel_check = y;
   endtask

   initial begin
      reset = 1'b0; in_valid = '0; colour_i = '0; xpixel_i = '0; ypixel_i = '0;
      out_ready = 1'b0; set_check('0, '0);
      m_ov = 1'b0; m_col = '0; m_x = '0; m_y = '0;
      for (int c = 0; c < NC; c++) begin last_v[c] = 1'b0; last_x[c] = '0; end
      @(posedge clk); #1;
      cycle(); cycle();
      reset = 1'b1;
      #1;
      chk("rst_in_ready", in_ready, 4'hF);
      chk("rst_empty",    empty,    4'hF);
      chk("rst_full",     full_queue, 4'h0);
      chk("rst_match",    match,    1'b0);
      chk("rst_stall",    stall,    1'b0);
      chk("rst_out_valid", out_valid, 1'b0);

      // Single push, popped with latency 1
      set_check(10'd5, 10'd2); out_ready = 1'b1;
      drive(0, 24'hFF0000, 10'd5, 10'd2);
      cycle();
      idle();
      cycle();
      chk("single_out_valid", out_valid, 1'b1);
      chk("single_colour",    colour_o,  24'hFF0000);
      chk("single_empty0",    empty[0],  1'b1);
      cycle();

      // Fill ch1, overflow push ignored, one pop frees a slot, then drain
      set_check(10'h3FF, 10'h3FF);
      for (int i = 0; i < QS + 1; i++) begin
         drive(1, 24'($urandom), 10'(i), 10'd0);
         cycle();
      end
      idle();
      chk("full_flag1",  full_queue[1], 1'b1);
      chk("full_ready1", in_ready[1],   1'b0);
      set_check(10'd0, 10'd0);
      cycle();
      chk("after_pop_ready1", in_ready[1], 1'b1);
      for (int i = 1; i < QS; i++) begin
         set_check(10'(i), 10'd0);
         cycle();
      end
      chk("drained_empty1", empty[1], 1'b1);
      cycle();

      // Two channels with identical heads: lowest index goes first
      drive(0, 24'hAAAAAA, 10'd3, 10'd0);
      drive(2, 24'hBBBBBB, 10'd3, 10'd0);
      set_check(10'd3, 10'd0);
      cycle();
      idle();
      cycle();
      chk("prio_first",  colour_o, 24'hAAAAAA);
      cycle();
      chk("prio_second", colour_o, 24'hBBBBBB);
      cycle();

      // Back-pressure: output held for 5 cycles, exactly one entry popped
      out_ready = 1'b0;
      set_check(10'd4, 10'd0);
      drive(0, 24'h000001, 10'd4, 10'd0);
      drive(1, 24'h000002, 10'd4, 10'd0);
      drive(2, 24'h000003, 10'd4, 10'd0);
      cycle();
      idle();
      cycle();
      for (int i = 0; i < 5; i++) begin
         chk("hold_colour", colour_o, 24'h000001);
         chk("hold_ch1",    empty[1], 1'b0);
         cycle();
      end
      out_ready = 1'b1;
      cycle();
      chk("release_colour", colour_o, 24'h000002);
      cycle(); cycle(); cycle();

      // Dedup on vs off: two consecutive pushes of x=7 on ch3
      reset = 1'b0;
      cycle();
      reset = 1'b1;
      set_check(10'h3FF, 10'h3FF);
      drive(3, 24'h123456, 10'd7, 10'd1);
      cycle();
      drive(3, 24'h654321, 10'd7, 10'd1);
      cycle();
      idle();
      set_check(10'd7, 10'd1);
      cycle();
      chk("dedup_empty3",   empty[3],    1'b1);
      chk("nodedup_empty3", nd_empty[3], 1'b0);
      cycle();
      chk("nodedup_second", nd_colour_o, 24'h654321);
      cycle();

      // All channels occupied with non-matching heads -> stall, then reset mid-stream
      set_check(10'd0, 10'd0);
      for (int i = 0; i < 4; i++) begin
         for (int c = 0; c < NC; c++) drive(c, 24'($urandom), 10'(1 + (i % 2)), 10'd5);
         cycle();
      end
      idle();
      cycle();
      chk("stall_full", stall, 1'b1);
      for (int c = 0; c < NC; c++) drive(c, 24'($urandom), 10'd0, 10'd0);
      reset = 1'b0;
      cycle();
      reset = 1'b1;
      idle();
      chk("midrst_empty", empty,     4'hF);
      chk("midrst_valid", out_valid, 1'b0);
      cycle();

      // Randomized traffic against the model
      for (int n = 0; n < 400; n++) begin
         reset = ($urandom_range(0, 99) != 0);
         for (int c = 0; c < NC; c++) begin
            in_valid[c] = ($urandom_range(0, 2) == 0);
            colour_i[c*CW +: CW] = 24'($urandom);
            xpixel_i[c*DW +: DW] = 10'($urandom_range(0, 3));
            ypixel_i[c*DW +: DW] = 10'($urandom_range(0, 1));
         end
         set_check(10'($urandom_range(0, 2)), 10'($urandom_range(0, 1)));
         out_ready = ($urandom_range(0, 3) != 0);
         cycle();
      end
      idle();
      reset = 1'b1;
      cycle();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/pixel_reorder_queue.md
PIXEL_REORDER_QUEUE -- requirements
Module: pixel_reorder_queue

Interface
REQ-001 Parameter DATA_WIDTH, default 10: pixel coordinate width in bits.
REQ-002 Parameter RBG_SIZE, default 24: colour width in bits.
REQ-003 Parameter QUEUE_SIZE, default 8: entries per channel, power of two, at least 2.
REQ-004 Parameter NUM_CH, default 4: number of engine input channels, at least 1.
REQ-005 Parameter DEDUP, default 1: 1 drops a push whose x equals the channel's last accepted x.
REQ-006 Clocking and reset: one clock, clk, rising edge only; reset is synchronous and active-low.
REQ-007 Port clk, input, 1: system clock.
REQ-008 Port reset, input, 1: synchronous active-low reset.
REQ-009 Port in_valid, input, NUM_CH: per-channel push request from engines.
REQ-010 Port in_ready, output, NUM_CH: per-channel not-full.
REQ-011 Ports colour_i, xpixel_i, ypixel_i, inputs: NUM_CH×RBG_SIZE, NUM_CH×DATA_WIDTH, NUM_CH×DATA_WIDTH; packed per channel.
REQ-012 Ports xpixel_check, ypixel_check, inputs, DATA_WIDTH each: next coordinate expected by the combinator.
REQ-013 Port out_ready, input, 1: combinator accepts the output.
REQ-014 Port out_valid, output, 1: colour_o, xpixel_o and ypixel_o are valid.
REQ-015 Ports colour_o, xpixel_o, ypixel_o, outputs: RBG_SIZE, DATA_WIDTH, DATA_WIDTH; registered.
REQ-016 Port match, output, 1: combinational; some non-empty channel head equals (xpixel_check, ypixel_check).
REQ-017 Port full_queue, output, NUM_CH: per-channel count == QUEUE_SIZE.
REQ-018 Port empty, output, NUM_CH: per-channel count == 0.
REQ-019 Port stall, output, 1: every channel non-empty, match low, and out_valid low.

Function
REQ-020 Each channel is an independent circular FIFO with read pointer, write pointer and a count of width $clog2(QUEUE_SIZE+1).
REQ-021 Push on channel c when in_valid[c] && in_ready[c]; in_ready[c] = !full_queue[c], with no dependence on a same-cycle pop.
REQ-022 With DEDUP=1, a push whose xpixel_i equals the channel's last accepted x is consumed but not stored; the last-accepted register is invalid after reset, so the first push is always stored.
REQ-023 Match compares head x and y of every non-empty channel against the check inputs; empty channels never match.
REQ-024 Several channels matching selects the lowest channel index.
REQ-025 Pop fire = match && (!out_valid || out_ready); the selected head loads the output registers and out_valid is 1 on the next cycle (latency 1).
REQ-026 out_valid stays high and the outputs stay stable until out_ready is seen high; out_valid is cleared when out_ready is high and no new fire occurs.
REQ-027 Push and pop on the same channel in the same cycle both occur, and count is unchanged.
REQ-028 A push into an empty channel is not visible to match until the next cycle; there is no bypass.
REQ-029 Pointers wrap modulo QUEUE_SIZE; count never exceeds QUEUE_SIZE and never underflows.

Reset
REQ-030 While reset is low at a clk edge: all counts, pointers and out_valid are 0, the last-accepted registers are invalid, and colour_o, xpixel_o and ypixel_o are 0.
REQ-031 Reset in mid-operation discards all stored entries and any pending output; no push or pop takes effect during a reset cycle.
REQ-032 After reset: in_ready is all ones, empty is all ones, full_queue is 0, match is 0 and stall is 0.

Structure
REQ-033 Package pixel_pkg holds coord_t (DATA_WIDTH), colour_t (RBG_SIZE) and the pixel_entry_t struct {colour, x, y}.
REQ-034 Sub-module pixel_fifo implements one channel (storage, pointers, count, dedup) and is instantiated NUM_CH times by generate.
REQ-035 The top level holds only the match/priority logic, the output register and the handshake; there is no negedge logic.

Verification
REQ-036 Reset, then ch0 pushes (x=5,y=2,c=0xFF0000) with check=(5,2) and out_ready=1 -> out_valid=1 two cycles after the push, colour_o=0xFF0000, empty[0]=1.
REQ-037 QUEUE_SIZE=8: push 8 entries to ch1 -> full_queue[1]=1, in_ready[1]=0; a 9th push is ignored; one pop restores in_ready[1]=1.
REQ-038 ch0 head=(3,0) and ch2 head=(3,0), check=(3,0) -> ch0 is popped first and ch2 on the next fire.
REQ-039 out_ready=0 for 5 cycles while matching -> outputs are held, exactly one entry is popped, and the next pop occurs on the cycle out_ready=1.
REQ-040 DEDUP=1: ch3 pushes x=7 twice consecutively -> count=1; DEDUP=0 -> count=2.
REQ-041 Fill all channels with non-matching heads, check=(0,0) -> stall=1; assert reset mid-stream -> all empty next cycle and out_valid=0.
